ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 8, giving the consecutive data grants allowed while an instruction request waits.
REQ-002 The block SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port req_ren  input  4  per-requester read request (index 0,1 = icache0/1; 2,3 = dcache0/1).
REQ-005 The block SHALL have port req_wen  input  4  per-requester write request.
REQ-006 The block SHALL have port req_addr  input  4x32  per-requester word address.
REQ-007 The block SHALL have port req_store  input  4x32  per-requester write data.
REQ-008 The block SHALL have port req_wait  output  4  per-requester stall; 0 only on the completion cycle.
REQ-009 The block SHALL have port req_load  output  4x32  per-requester read data, valid when its req_wait=0.
REQ-010 The block SHALL have ports ramREN/ramWEN  output  1 each, ramaddr/ramstore  output  32 each; ramload  input  32; ramstate  input  ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-011 The block SHALL use states IDLE, GRANT and RELEASE.
REQ-012 In IDLE, if any req_ren|req_wen bit is set, the block SHALL register a grant index g and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-013 Arbitration SHALL give data requesters (2,3) priority over instruction requesters (0,1), except as stated in REQ-019.
REQ-014 Within a class, arbitration SHALL be round-robin: a one-bit pointer per class SHALL favour the requester not granted last in that class, and SHALL toggle only on completion.
REQ-015 In GRANT, the block SHALL drive ramaddr=req_addr[g].
REQ-016 In GRANT, the block SHALL drive ramWEN=req_wen[g] and ramstore=req_store[g]; ramREN SHALL be req_ren[g] & ~req_wen[g], so write wins when both are set.
REQ-017 In GRANT with ramstate==ACCESS, the block SHALL drive req_wait[g]=0 and req_load[g]=ramload combinationally, then go to RELEASE.
REQ-018 In RELEASE, the block SHALL drive all RAM controls to 0 and all req_wait to 1, and SHALL go to IDLE. This gives one dead cycle so the requester can drop its request.
REQ-019 A saturating starvation counter SHALL increment on each completed data grant while any instruction request is pending, and SHALL clear on a completed instruction grant. When the counter equals STARVE_MAX, the next arbitration SHALL pick the instruction class.
REQ-020 If req_ren[g] and req_wen[g] both drop in GRANT before ACCESS, the block SHALL abort to IDLE with no completion and no pointer or counter update.
REQ-021 ramstate ERROR or BUSY in GRANT SHALL keep the block in GRANT with request signals held (retry).
REQ-022 Non-granted requesters SHALL see req_wait=1 and req_load=0 at all times.
REQ-023 A grant SHALL last minimum latency 3 cycles: arbitrate, ACCESS, release.

Reset
REQ-024 On RST high, state SHALL go to IDLE, g=0, both round-robin pointers=0 and starvation counter=0, all asynchronously.
REQ-025 During reset, outputs SHALL be ramREN=ramWEN=0, ramaddr=ramstore=0, req_wait=4'b1111, req_load=0.
REQ-026 Reset asserted mid-GRANT SHALL deassert RAM controls immediately, with no completion reported.

Structure
REQ-027 ramstate_t, word_t (32-bit) and requester index constants SHALL come from cpu_types_pkg; the arbiter state enum SHALL stay local.
REQ-028 One sub-module rr_pick2 (two-request round-robin picker with pointer) SHALL be instantiated once per class.

Verification
REQ-029 Reset, then hold all requests low -> IDLE persists; RAM controls stay 0; req_wait=4'b1111.
REQ-030 req_ren[0] at addr 0x40, RAM returns ACCESS with 0xDEADBEEF on the second GRANT cycle -> req_wait[0]=0 and req_load[0]=0xDEADBEEF on that cycle only; RELEASE follows.
REQ-031 req_ren[0] and req_wen[2] together -> requester 2 is served first (ramWEN=1, ramstore=req_store[2]), then requester 0.
REQ-032 req_wen[2] and req_wen[3] continuously asserted -> grants alternate 2,3,2,3.
REQ-033 Data requests continuous plus req_ren[1] held, STARVE_MAX=8 -> requester 1 is granted after exactly 8 data completions.
REQ-034 Request dropped in GRANT, or RST pulsed mid-GRANT -> return to IDLE, no req_wait deassertion, pointers unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake states, word type and
// requester indices used by the memory arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned NREQ = 4;

  localparam logic [1:0] ICACHE0 = 2'd0;
  localparam logic [1:0] ICACHE1 = 2'd1;
  localparam logic [1:0] DCACHE0 = 2'd2;
  localparam logic [1:0] DCACHE1 = 2'd3;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-requester round-robin picker. The pointer names the favoured requester
// and moves to the other one only when a grant of this class completes.
module rr_pick2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_idx_i,
  output logic       any_o,
  output logic       pick_o
);

  logic ptr_q;
  logic ptr_d;

  // Pick the favoured requester if it is asking, otherwise the other one.
  always_comb begin
    any_o = |req_i;
    if (req_i[ptr_q]) begin
      pick_o = ptr_q;
    end else begin
      pick_o = ~ptr_q;
    end
  end

  // Pointer next state: favour whoever was not served last.
  always_comb begin
    if (done_i) begin
      ptr_d = ~done_idx_i;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Four-port RAM arbiter: dcaches beat icaches, round-robin within each class,
// with a starvation counter that forces an icache grant after STARVE_MAX data grants.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      req_ren,
  input  logic [3:0]      req_wen,
  input  word_t [3:0]     req_addr,
  input  word_t [3:0]     req_store,
  output logic [3:0]      req_wait,
  output word_t [3:0]     req_load,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

  arb_state_t    state_q;
  logic [1:0]    g_q;
  logic [CW-1:0] cnt_q;

  logic [3:0] req_any_s;
  logic       i_any_s, d_any_s, i_pick_s, d_pick_s;
  logic       pick_instr_s, g_active_s, done_s;
  logic [1:0] g_d;

  assign req_any_s = req_ren | req_wen;

  rr_pick2 u_pick_i (
    .clk_i      (CLK),
    .rst_i      (RST),
    .req_i      (req_any_s[1:0]),
    .done_i     (done_s & ~g_q[1]),
    .done_idx_i (g_q[0]),
    .any_o      (i_any_s),
    .pick_o     (i_pick_s)
  );

  rr_pick2 u_pick_d (
    .clk_i      (CLK),
    .rst_i      (RST),
    .req_i      (req_any_s[3:2]),
    .done_i     (done_s & g_q[1]),
    .done_idx_i (g_q[0]),
    .any_o      (d_any_s),
    .pick_o     (d_pick_s)
  );

  // Class selection and grant completion detection.
  always_comb begin
    pick_instr_s = ~d_any_s | (i_any_s & (cnt_q == CMAX));
    if (pick_instr_s) begin
      g_d = {1'b0, i_pick_s};
    end else begin
      g_d = {1'b1, d_pick_s};
    end
    g_active_s = req_any_s[g_q];
    done_s     = (state_q == GRANT) & g_active_s & (ramstate == ACCESS);
  end

  // Arbiter FSM, grant index and starvation counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_any_s) begin
            g_q     <= g_d;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // A requester that withdraws before ACCESS aborts without completion.
          if (!g_active_s) begin
            state_q <= IDLE;
          end else if (ramstate == ACCESS) begin
            state_q <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (done_s && !g_q[1]) begin
        cnt_q <= '0;
      end else if (done_s && g_q[1] && i_any_s && (cnt_q != CMAX)) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // RAM-side drive and per-requester completion; only GRANT touches the RAM.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = 4'b1111;
    req_load = '0;
    if (state_q == GRANT) begin
      ramaddr  = req_addr[g_q];
      ramstore = req_store[g_q];
      ramWEN   = req_wen[g_q];
      ramREN   = req_ren[g_q] & ~req_wen[g_q];
      if (done_s) begin
        req_wait[g_q] = 1'b0;
        req_load[g_q] = ramload;
      end else begin
        req_wait = 4'b1111;
      end
    end else begin
      ramREN = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: hand-computed grant order, timing and reset behaviour.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic [3:0]       req_ren, req_wen, req_wait;
  logic [3:0][31:0] req_addr, req_store, req_load;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_arbiter #(.STARVE_MAX(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req_ren  (req_ren),
    .req_wen  (req_wen),
    .req_addr (req_addr),
    .req_store(req_store),
    .req_wait (req_wait),
    .req_load (req_load),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // From IDLE with requests up and ramstate=ACCESS: one full 3-cycle grant.
  task automatic grant_once(input string tag, input int idx);
    logic [3:0] e;
    e = 4'b1111;
    e[idx] = 1'b0;
    tick();
    chk(tag, {28'd0, req_wait}, {28'd0, e});
    tick();
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    req_ren   = 4'b0000;
    req_wen   = 4'b0000;
    req_addr  = '0;
    req_store = '0;
    ramload   = 32'h0;
    ramstate  = FREE;
    req_addr[0] = 32'h0000_0040;
    req_addr[1] = 32'h0000_0044;
    req_addr[2] = 32'h0000_0080;
    req_addr[3] = 32'h0000_0084;
    req_store[2] = 32'h1234_5678;
    req_store[3] = 32'hCAFE_F00D;

    #3;
    chk("rst_wait", {28'd0, req_wait}, 32'h0000_000F);
    chk("rst_ren", {31'd0, ramREN}, 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_load", req_load[0], 32'd0);
    tick();
    RST = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_wait", {28'd0, req_wait}, 32'h0000_000F);
      chk("idle_ctl", {30'd0, ramREN, ramWEN}, 32'd0);
    end

    // Single icache0 read, ACCESS on the second GRANT cycle.
    req_ren  = 4'b0001;
    ramstate = BUSY;
    #1;
    chk("rd_arb_wait", {28'd0, req_wait}, 32'h0000_000F);
    chk("rd_arb_ren", {31'd0, ramREN}, 32'd0);
    tick();
    chk("rd_g1_ren", {31'd0, ramREN}, 32'd1);
    chk("rd_g1_addr", ramaddr, 32'h0000_0040);
    chk("rd_g1_wait", {28'd0, req_wait}, 32'h0000_000F);
    ramstate = ACCESS;
    ramload  = 32'hDEAD_BEEF;
    #1;
    chk("rd_g2_wait", {28'd0, req_wait}, 32'h0000_000E);
    chk("rd_g2_load0", req_load[0], 32'hDEAD_BEEF);
    chk("rd_g2_load1", req_load[1], 32'd0);
    tick();
    ramstate = FREE;
    req_ren  = 4'b0000;
    #1;
    chk("rd_rel_wait", {28'd0, req_wait}, 32'h0000_000F);
    chk("rd_rel_ren", {31'd0, ramREN}, 32'd0);
    chk("rd_rel_load", req_load[0], 32'd0);
    tick();

    // icache0 read and dcache0 write together: data first.
    req_ren  = 4'b0001;
    req_wen  = 4'b0100;
    ramstate = ACCESS;
    #1;
    tick();
    chk("prio_wen", {31'd0, ramWEN}, 32'd1);
    chk("prio_ren", {31'd0, ramREN}, 32'd0);
    chk("prio_store", ramstore, 32'h1234_5678);
    chk("prio_addr", ramaddr, 32'h0000_0080);
    chk("prio_wait_d", {28'd0, req_wait}, 32'h0000_000B);
    tick();
    req_wen = 4'b0000;
    tick();
    tick();
    chk("prio_wait_i", {28'd0, req_wait}, 32'h0000_000E);
    chk("prio_ren_i", {31'd0, ramREN}, 32'd1);
    chk("prio_addr_i", ramaddr, 32'h0000_0040);
    tick();
    req_ren = 4'b0000;
    tick();

    // Fresh reset, then continuous dcache writes alternate 2,3,2,3.
    RST = 1'b1;
    #1;
    RST = 1'b0;
    req_wen = 4'b1100;
    for (int k = 0; k < 4; k++) grant_once("rr_data", (k % 2 == 0) ? 2 : 3);

    // Starvation: eight data completions, then icache1, then data resumes.
    req_ren = 4'b0010;
    for (int k = 0; k < 8; k++) grant_once("starve_data", (k % 2 == 0) ? 2 : 3);
    grant_once("starve_instr", 1);
    grant_once("starve_after", 2);
    req_ren = 4'b0000;
    req_wen = 4'b0000;

    // ERROR retries in GRANT; withdrawal aborts without completion.
    ramstate = ERROR;
    req_ren  = 4'b0001;
    #1;
    tick();
    chk("retry_ren1", {31'd0, ramREN}, 32'd1);
    chk("retry_wait1", {28'd0, req_wait}, 32'h0000_000F);
    tick();
    chk("retry_ren2", {31'd0, ramREN}, 32'd1);
    chk("retry_addr", ramaddr, 32'h0000_0040);
    req_ren = 4'b0000;
    #1;
    chk("abort_ren", {31'd0, ramREN}, 32'd0);
    chk("abort_wait", {28'd0, req_wait}, 32'h0000_000F);
    tick();
    chk("abort_idle_wait", {28'd0, req_wait}, 32'h0000_000F);
    ramstate = ACCESS;
    req_ren  = 4'b0011;
    grant_once("abort_ptr_kept", 0);
    req_ren = 4'b0000;

    // Reset pulsed mid-GRANT kills RAM controls at once, no completion.
    ramstate = BUSY;
    req_ren  = 4'b0010;
    #1;
    tick();
    chk("rstg_ren_pre", {31'd0, ramREN}, 32'd1);
    chk("rstg_addr_pre", ramaddr, 32'h0000_0044);
    RST      = 1'b1;
    ramstate = ACCESS;
    #1;
    chk("rstg_ren", {31'd0, ramREN}, 32'd0);
    chk("rstg_addr", ramaddr, 32'd0);
    chk("rstg_wait", {28'd0, req_wait}, 32'h0000_000F);
    chk("rstg_load", req_load[1], 32'd0);
    #1;
    RST     = 1'b0;
    req_ren = 4'b0000;
    tick();
    req_ren = 4'b0011;
    grant_once("rstg_ptr_reset", 0);
    req_ren = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
